multicycle_control: RTL and testbench

Moore finite-state controller that sequences the shared-ALU, multi-cycle RV32I datapath. It drives the datapath control signals listed under Interface, including `ImmSrc` to the immediate extender. It also runs a req/ready handshake with a unified instruction/data memory. The controller sits beside the instruction register and consumes the latched instruction and the ALU zero flag.

---
 rtl/multicycle_control.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer for a shared-ALU multi-cycle RV32I datapath with req/ready memory handshake
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   instr                 latched instruction register contents
//   zero                  ALU zero flag (used by BRANCH)
//   mem_ready             memory completes the outstanding request this cycle
//   mem_req, mem_we       memory request / write qualifier
//   adr_src               memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write    instruction register / PC load enables
//   reg_write             register-file write enable
//   ImmSrc                immediate extender select, decoded from the opcode
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                ALU operation class
//   result_src            result mux select
//   illegal               sticky trap indicator
//   state                 current state code
module multicycle_control #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [2:0]       ImmSrc,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             illegal,
    output logic [3:0]       state
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        LUI      = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10,
        JAL      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic       mem_req_q, mem_we_q, adr_src_q, reg_write_q, jal_pc_q, illegal_q;
    logic [1:0] alu_src_a_q, alu_src_b_q, alu_op_q, result_src_q;
    logic [6:0] opcode;
    logic       is_ld, is_st, is_r, is_i, is_lui, is_br, is_jal, br_ok;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign is_ld        = opcode == 7'b0000011;
    assign is_st        = opcode == 7'b0100011;
    assign is_r         = opcode == 7'b0110011;
    assign is_i         = opcode == 7'b0010011;
    assign is_lui       = opcode == 7'b0110111;
    assign is_br        = opcode == 7'b1100011;
    assign is_jal       = opcode == 7'b1101111;
    // only beq/bne are supported; funct3[2:1] must be zero
    assign br_ok        = instr[14:13] == 2'b00;
    assign unused_instr = ^{instr[Width-1:15], instr[11:7]};

    always_comb begin
        ImmSrc = is_st  ? 3'b001 :
                 is_br  ? 3'b010 :
                 is_r   ? 3'b011 :
                 is_lui ? 3'b100 :
                 is_jal ? 3'b101 : 3'b000;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // mem_req_q is low only in the first cycle after reset, so ready is ignored there
            FETCH:    state_d = (mem_req_q && mem_ready) ? DECODE : FETCH;
            DECODE:   state_d = (is_ld || is_st) ? MEMADR :
                                is_r             ? EXECR  :
                                is_i             ? EXECI  :
                                is_lui           ? LUI    :
                                (is_br && br_ok) ? BRANCH :
                                is_jal           ? JAL    : TRAP;
            MEMADR:   state_d = is_ld ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            MEMWB:    state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            LUI:      state_d = ALUWB;
            JAL:      state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            adr_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            jal_pc_q     <= 1'b0;
            illegal_q    <= 1'b0;
            alu_src_a_q  <= 2'b00;
            alu_src_b_q  <= 2'b10;
            alu_op_q     <= 2'b00;
            result_src_q <= 2'b10;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            adr_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            jal_pc_q     <= 1'b0;
            illegal_q    <= 1'b0;
            alu_src_a_q  <= 2'b00;
            alu_src_b_q  <= 2'b00;
            alu_op_q     <= 2'b00;
            result_src_q <= 2'b00;
            case (state_d)
                FETCH: begin
                    mem_req_q    <= 1'b1;
                    alu_src_b_q  <= 2'b10;
                    result_src_q <= 2'b10;
                end
                DECODE: begin
                    alu_src_a_q <= 2'b01;
                    alu_src_b_q <= 2'b01;
                end
                MEMADR: begin
                    alu_src_a_q <= 2'b10;
                    alu_src_b_q <= 2'b01;
                end
                MEMREAD: begin
                    mem_req_q <= 1'b1;
                    adr_src_q <= 1'b1;
                end
                MEMWB: begin
                    result_src_q <= 2'b01;
                    reg_write_q  <= 1'b1;
                end
                MEMWRITE: begin
                    mem_req_q <= 1'b1;
                    mem_we_q  <= 1'b1;
                    adr_src_q <= 1'b1;
                end
                EXECR: begin
                    alu_src_a_q <= 2'b10;
                    alu_op_q    <= 2'b10;
                end
                EXECI: begin
                    alu_src_a_q <= 2'b10;
                    alu_src_b_q <= 2'b01;
                    alu_op_q    <= 2'b10;
                end
                LUI: begin
                    alu_src_a_q <= 2'b11;
                    alu_src_b_q <= 2'b01;
                end
                ALUWB: reg_write_q <= 1'b1;
                BRANCH: begin
                    alu_src_a_q <= 2'b10;
                    alu_op_q    <= 2'b01;
                end
                JAL: begin
                    alu_src_a_q <= 2'b01;
                    alu_src_b_q <= 2'b10;
                    jal_pc_q    <= 1'b1;
                end
                TRAP:    illegal_q <= 1'b1;
                default: illegal_q <= 1'b0;
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign adr_src    = adr_src_q;
    assign reg_write  = reg_write_q;
    assign illegal    = illegal_q;
    assign alu_src_a  = alu_src_a_q;
    assign alu_src_b  = alu_src_b_q;
    assign alu_op     = alu_op_q;
    assign result_src = result_src_q;
    assign state      = state_q;
    // The fetch handshake completes in the same cycle mem_ready is seen
    assign ir_write   = (state_q == FETCH) && mem_req_q && mem_ready;
    assign pc_write   = ir_write || jal_pc_q || ((state_q == BRANCH) && (zero ^ instr[12]));
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [2:0]  ImmSrc;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0]  state;
    int          checks = 0;
    int          passed = 0;

    multicycle_control #(.Width(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .ImmSrc(ImmSrc),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        checks++; if (state !== 4'd0) $display("FAIL reset_state got %0d exp 0", state); else passed++;
        checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_req); else passed++;
        checks++; if (ir_write !== 1'b0) $display("FAIL reset_ir_write got %b exp 0", ir_write); else passed++;
        checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal got %b exp 0", illegal); else passed++;
        rst_n = 1'b1;
        tick();
        checks++; if (state !== 4'd0) $display("FAIL ready_ignored_state got %0d exp 0", state); else passed++;
        checks++; if (mem_req !== 1'b1) $display("FAIL fetch_mem_req got %b exp 1", mem_req); else passed++;
    endtask

    task automatic test_add();
        instr = 32'h002081B3;
        mem_ready = 1'b1;
        #1;
        checks++; if (ir_write !== 1'b1 || pc_write !== 1'b1) $display("FAIL add_fetch_we got ir=%b pc=%b exp 1 1", ir_write, pc_write); else passed++;
        checks++; if (alu_src_b !== 2'b10 || result_src !== 2'b10 || adr_src !== 1'b0) $display("FAIL add_fetch_sel got b=%b rs=%b adr=%b exp 10 10 0", alu_src_b, result_src, adr_src); else passed++;
        checks++; if (ImmSrc !== 3'b011) $display("FAIL add_immsrc got %b exp 011", ImmSrc); else passed++;
        tick();
        checks++; if (state !== 4'd1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b01 || ir_write !== 1'b0) $display("FAIL add_decode got st=%0d a=%b b=%b ir=%b exp 1 01 01 0", state, alu_src_a, alu_src_b, ir_write); else passed++;
        tick();
        checks++; if (state !== 4'd6 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00 || alu_op !== 2'b10) $display("FAIL add_execr got st=%0d a=%b b=%b op=%b exp 6 10 00 10", state, alu_src_a, alu_src_b, alu_op); else passed++;
        tick();
        checks++; if (state !== 4'd9 || reg_write !== 1'b1 || result_src !== 2'b00) $display("FAIL add_aluwb got st=%0d rw=%b rs=%b exp 9 1 00", state, reg_write, result_src); else passed++;
        checks++; if (ImmSrc !== 3'b011) $display("FAIL add_immsrc_late got %b exp 011", ImmSrc); else passed++;
        tick();
        checks++; if (state !== 4'd0 || reg_write !== 1'b0 || mem_req !== 1'b1) $display("FAIL add_refetch got st=%0d rw=%b req=%b exp 0 0 1", state, reg_write, mem_req); else passed++;
    endtask

    task automatic test_lw_wait();
        int n;
        instr = 32'h0000A103;
        mem_ready = 1'b1;
        n = 0;
        #1;
        checks++; if (ImmSrc !== 3'b000) $display("FAIL lw_immsrc got %b exp 000", ImmSrc); else passed++;
        tick(); n++;
        tick(); n++;
        checks++; if (state !== 4'd2 || alu_src_a !== 2'b10 || alu_src_b !== 2'b01) $display("FAIL lw_memadr got st=%0d a=%b b=%b exp 2 10 01", state, alu_src_a, alu_src_b); else passed++;
        mem_ready = 1'b0;
        tick(); n++;
        checks++; if (state !== 4'd3 || mem_req !== 1'b1 || adr_src !== 1'b1 || mem_we !== 1'b0) $display("FAIL lw_memread got st=%0d req=%b adr=%b we=%b exp 3 1 1 0", state, mem_req, adr_src, mem_we); else passed++;
        tick(); n++;
        checks++; if (state !== 4'd3 || mem_req !== 1'b1 || adr_src !== 1'b1) $display("FAIL lw_wait1 got st=%0d req=%b adr=%b exp 3 1 1", state, mem_req, adr_src); else passed++;
        tick(); n++;
        checks++; if (state !== 4'd3 || mem_req !== 1'b1 || adr_src !== 1'b1) $display("FAIL lw_wait2 got st=%0d req=%b adr=%b exp 3 1 1", state, mem_req, adr_src); else passed++;
        mem_ready = 1'b1;
        tick(); n++;
        checks++; if (state !== 4'd4 || result_src !== 2'b01 || reg_write !== 1'b1 || mem_req !== 1'b0) $display("FAIL lw_memwb got st=%0d rs=%b rw=%b req=%b exp 4 01 1 0", state, result_src, reg_write, mem_req); else passed++;
        tick(); n++;
        checks++; if (state !== 4'd0 || n !== 7) $display("FAIL lw_cycles got st=%0d n=%0d exp 0 7", state, n); else passed++;
    endtask

    task automatic test_branch(input logic [31:0] ins, input logic exp_pc, input string name);
        instr = ins;
        zero = 1'b1;
        mem_ready = 1'b1;
        tick();
        checks++; if (state !== 4'd1 || ImmSrc !== 3'b010) $display("FAIL %s_decode got st=%0d imm=%b exp 1 010", name, state, ImmSrc); else passed++;
        tick();
        #1;
        checks++; if (state !== 4'd10 || pc_write !== exp_pc || alu_op !== 2'b01 || alu_src_a !== 2'b10) $display("FAIL %s_branch got st=%0d pcw=%b op=%b a=%b exp 10 %b 01 10", name, state, pc_write, alu_op, alu_src_a, exp_pc); else passed++;
        tick();
        checks++; if (state !== 4'd0) $display("FAIL %s_cycles got st=%0d exp 0", name, state); else passed++;
        zero = 1'b0;
    endtask

    task automatic test_jal();
        instr = 32'h008000EF;
        mem_ready = 1'b1;
        tick();
        tick();
        checks++; if (state !== 4'd11 || pc_write !== 1'b1 || ImmSrc !== 3'b101) $display("FAIL jal_state got st=%0d pcw=%b imm=%b exp 11 1 101", state, pc_write, ImmSrc); else passed++;
        checks++; if (alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || reg_write !== 1'b0) $display("FAIL jal_sel got a=%b b=%b rw=%b exp 01 10 0", alu_src_a, alu_src_b, reg_write); else passed++;
        tick();
        checks++; if (state !== 4'd9 || reg_write !== 1'b1 || pc_write !== 1'b0) $display("FAIL jal_aluwb got st=%0d rw=%b pcw=%b exp 9 1 0", state, reg_write, pc_write); else passed++;
        tick();
        checks++; if (state !== 4'd0) $display("FAIL jal_cycles got st=%0d exp 0", state); else passed++;
    endtask

    task automatic test_trap();
        int bad;
        instr = 32'h0000007F;
        mem_ready = 1'b1;
        tick();
        tick();
        checks++; if (state !== 4'd12 || illegal !== 1'b1) $display("FAIL trap_enter got st=%0d ill=%b exp 12 1", state, illegal); else passed++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state !== 4'd12 || illegal !== 1'b1 || mem_req !== 1'b0 || pc_write !== 1'b0 || reg_write !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL trap_sticky got %0d bad cycles exp 0", bad); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 4'd0 || illegal !== 1'b0) $display("FAIL trap_reset got st=%0d ill=%b exp 0 0", state, illegal); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (state !== 4'd0 || mem_req !== 1'b1) $display("FAIL trap_resume got st=%0d req=%b exp 0 1", state, mem_req); else passed++;
    endtask

    task automatic test_reset_midwrite();
        int bad;
        instr = 32'h0020A023;
        mem_ready = 1'b1;
        #1;
        checks++; if (ImmSrc !== 3'b001) $display("FAIL sw_immsrc got %b exp 001", ImmSrc); else passed++;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        checks++; if (state !== 4'd5 || mem_req !== 1'b1 || mem_we !== 1'b1 || adr_src !== 1'b1) $display("FAIL sw_memwrite got st=%0d req=%b we=%b adr=%b exp 5 1 1 1", state, mem_req, mem_we, adr_src); else passed++;
        tick();
        checks++; if (state !== 4'd5 || mem_req !== 1'b1 || mem_we !== 1'b1) $display("FAIL sw_wait got st=%0d req=%b we=%b exp 5 1 1", state, mem_req, mem_we); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== 4'd0) $display("FAIL midwrite_drop got req=%b we=%b st=%0d exp 0 0 0", mem_req, mem_we, state); else passed++;
        bad = 0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pc_write !== 1'b0 || reg_write !== 1'b0 || ir_write !== 1'b0 || mem_req !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL midwrite_enables got %0d bad cycles exp 0", bad); else passed++;
        rst_n = 1'b1;
        tick();
        checks++; if (state !== 4'd0 || mem_req !== 1'b1 || mem_we !== 1'b0) $display("FAIL midwrite_resume got st=%0d req=%b we=%b exp 0 1 0", state, mem_req, mem_we); else passed++;
        tick();
        checks++; if (state !== 4'd1) $display("FAIL midwrite_fetch got st=%0d exp 1", state); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch(32'h00000063, 1'b1, "beq");
        test_branch(32'h00001063, 1'b0, "bne");
        test_jal();
        test_trap();
        test_reset_midwrite();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
